// File: rtl/mcycle_param.sv
// mcycle_param: multi-cycle signed/unsigned shift-add multiplier and restoring divider.
// Optional build macro MCYCLE_EARLY_TERM_EN: multiplies stop once no multiplier bits remain.
module mcycle_param #(
   parameter int WIDTH = 32
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             Start,
   input  logic [1:0]       MCycleOp,
   input  logic [WIDTH-1:0] Operand1,
   input  logic [WIDTH-1:0] Operand2,
   output logic [WIDTH-1:0] Result1,
   output logic [WIDTH-1:0] Result2,
   output logic             Busy,
   output logic             Done,
   output logic             DivByZero
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPUTE = 2'd1,
      DONE    = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic               is_div_q;
   logic               res_neg_q;
   logic               rem_neg_q;
   logic               divz_q;
   logic [WIDTH-1:0]   op1_q;
   logic [CNT_W-1:0]   cnt_q;

   logic [2*WIDTH-1:0] prod_q, prod_d;
   logic [2*WIDTH-1:0] mcand_q;
   logic [WIDTH-1:0]   mplier_q;

   logic [WIDTH-1:0]   rem_q, rem_d;
   logic [WIDTH-1:0]   quo_q, quo_d;
   logic [WIDTH-1:0]   dvsr_q;

   logic [WIDTH-1:0]   res1_q, res2_q;
   logic               dbz_q;

   logic               start_go;
   logic               last_step;
   logic               in_signed;
   logic               in_neg1, in_neg2;
   logic [WIDTH-1:0]   in_mag1, in_mag2;

   logic [WIDTH:0]     div_shift;
   logic [WIDTH:0]     div_trial;
   logic               div_fits;

   logic [2*WIDTH-1:0] prod_fin;
   logic [WIDTH-1:0]   quo_fin, rem_fin;

   assign start_go = (state_q == IDLE) && Start;

   // The most-negative value negates to itself, which read unsigned is exactly 2^(WIDTH-1).
   always_comb begin
      in_signed = ~MCycleOp[0];
      in_neg1   = in_signed & Operand1[WIDTH-1];
      in_neg2   = in_signed & Operand2[WIDTH-1];
      in_mag1   = in_neg1 ? -Operand1 : Operand1;
      in_mag2   = in_neg2 ? -Operand2 : Operand2;
   end

   always_comb begin
      prod_d    = prod_q + (mplier_q[0] ? mcand_q : '0);
      div_shift = {rem_q, quo_q[WIDTH-1]};
      div_trial = div_shift - {1'b0, dvsr_q};
      div_fits  = ~div_trial[WIDTH];
      rem_d     = div_fits ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
      quo_d     = {quo_q[WIDTH-2:0], div_fits};
      prod_fin  = res_neg_q ? -prod_d : prod_d;
      quo_fin   = res_neg_q ? -quo_d : quo_d;
      rem_fin   = rem_neg_q ? -rem_d : rem_d;
   end

   always_comb begin
      last_step = 1'b0;
      if (divz_q) begin
         last_step = 1'b1;
      end else if (is_div_q) begin
         last_step = (cnt_q == CNT_W'(WIDTH - 1));
      end else begin
`ifdef MCYCLE_EARLY_TERM_EN
         last_step = ((mplier_q >> 1) == '0);
`else
         last_step = (cnt_q == CNT_W'(WIDTH - 1));
`endif
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (Start) state_d = COMPUTE;
         COMPUTE: if (last_step) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      Busy = 1'b0;
      Done = 1'b0;
      unique case (state_q)
         COMPUTE: Busy = 1'b1;
         DONE:    Done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         is_div_q  <= 1'b0;
         res_neg_q <= 1'b0;
         rem_neg_q <= 1'b0;
         divz_q    <= 1'b0;
         op1_q     <= '0;
         cnt_q     <= '0;
         prod_q    <= '0;
         mcand_q   <= '0;
         mplier_q  <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         dvsr_q    <= '0;
         res1_q    <= '0;
         res2_q    <= '0;
         dbz_q     <= 1'b0;
      end else if (start_go) begin
         is_div_q  <= MCycleOp[1];
         res_neg_q <= in_neg1 ^ in_neg2;
         rem_neg_q <= in_neg1;
         divz_q    <= MCycleOp[1] && (Operand2 == '0);
         op1_q     <= Operand1;
         cnt_q     <= '0;
         prod_q    <= '0;
         mcand_q   <= {{WIDTH{1'b0}}, in_mag1};
         mplier_q  <= in_mag2;
         rem_q     <= '0;
         quo_q     <= in_mag1;
         dvsr_q    <= in_mag2;
         dbz_q     <= 1'b0;
      end else if (state_q == COMPUTE) begin
         cnt_q <= cnt_q + CNT_W'(1);
         if (is_div_q) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
         end else begin
            prod_q   <= prod_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
         end
         if (last_step) begin
            if (divz_q) begin
               res1_q <= '1;
               res2_q <= op1_q;
               dbz_q  <= 1'b1;
            end else if (is_div_q) begin
               res1_q <= quo_fin;
               res2_q <= rem_fin;
            end else begin
               res1_q <= prod_fin[WIDTH-1:0];
               res2_q <= prod_fin[2*WIDTH-1:WIDTH];
            end
         end
      end
   end

   assign Result1   = res1_q;
   assign Result2   = res2_q;
   assign DivByZero = dbz_q;

endmodule
